// File: rtl/imem_program_encoder_if.sv
// Command stream and instruction-memory write port of the program encoder.
// The master side produces commands and acknowledges writes; the slave side is
// the encoder, which consumes commands and drives the memory write strobe.
interface imem_program_encoder_if #(
    parameter int unsigned ADDR_W = 8
);
    // Command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [4:0]        cmd_rs;
    logic [4:0]        cmd_rt;
    logic [4:0]        cmd_rd;
    logic [5:0]        cmd_funct;
    logic [15:0]       cmd_imm;
    logic [25:0]       cmd_target;
    logic              cmd_last;

    // Instruction-memory write port
    logic              imem_we;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_rs,
        output cmd_rt,
        output cmd_rd,
        output cmd_funct,
        output cmd_imm,
        output cmd_target,
        output cmd_last,
        output imem_ready,
        input  cmd_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_rs,
        input  cmd_rt,
        input  cmd_rd,
        input  cmd_funct,
        input  cmd_imm,
        input  cmd_target,
        input  cmd_last,
        input  imem_ready,
        output cmd_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/imem_program_encoder.sv
// MIPS32 program loader: encodes instruction descriptors received over a
// valid/ready command stream and writes them to consecutive instruction-memory
// words. Reports sticky illegal-opcode and memory-overflow flags.
module imem_program_encoder #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned START_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    imem_program_encoder_if.slave bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err_op,
    output logic                  overflow,
    output logic [ADDR_W:0]       word_count
);

    typedef enum logic [1:0] {
        StIdle,
        StAccept,
        StWrite,
        StDone
    } state_e;

    // Command opcodes
    localparam logic [2:0] OpR    = 3'd0;
    localparam logic [2:0] OpLw   = 3'd1;
    localparam logic [2:0] OpSw   = 3'd2;
    localparam logic [2:0] OpBeq  = 3'd3;
    localparam logic [2:0] OpAddi = 3'd4;
    localparam logic [2:0] OpJ    = 3'd5;

    // MIPS primary opcode fields
    localparam logic [5:0] MipsSpecial = 6'b000000;
    localparam logic [5:0] MipsLw      = 6'b100011;
    localparam logic [5:0] MipsSw      = 6'b101011;
    localparam logic [5:0] MipsBeq     = 6'b000100;
    localparam logic [5:0] MipsAddi    = 6'b001000;
    localparam logic [5:0] MipsJ       = 6'b000010;

    localparam logic [ADDR_W-1:0] StartAddr = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] LastAddr  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] AddrOne   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CountOne  = (ADDR_W + 1)'(1);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              last_q;
    logic [ADDR_W:0]   count_q;
    logic              err_q;
    logic              ovf_q;
    logic              cmd_ready_q;
    logic              we_q;
    logic              busy_q;
    logic              done_q;

    logic [31:0]       enc_word;
    logic              enc_legal;
    logic              cmd_fire;

    // Encode the command currently presented; shamt is always zero.
    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (bus.cmd_op)
            OpR: enc_word = {MipsSpecial, bus.cmd_rs, bus.cmd_rt, bus.cmd_rd, 5'b00000,
                             bus.cmd_funct};
            OpLw:   enc_word = {MipsLw, bus.cmd_rs, bus.cmd_rt, bus.cmd_imm};
            OpSw:   enc_word = {MipsSw, bus.cmd_rs, bus.cmd_rt, bus.cmd_imm};
            OpBeq:  enc_word = {MipsBeq, bus.cmd_rs, bus.cmd_rt, bus.cmd_imm};
            OpAddi: enc_word = {MipsAddi, bus.cmd_rs, bus.cmd_rt, bus.cmd_imm};
            OpJ:    enc_word = {MipsJ, bus.cmd_target};
            default: enc_legal = 1'b0;
        endcase
    end

    // cmd_ready_q is only ever set in ACCEPT, so this is the handshake.
    assign cmd_fire = bus.cmd_valid & cmd_ready_q;

    // Load sequencer; all outputs are registered and set alongside the transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            addr_q      <= StartAddr;
            wdata_q     <= 32'h0;
            last_q      <= 1'b0;
            count_q     <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        addr_q      <= StartAddr;
                        count_q     <= '0;
                        err_q       <= 1'b0;
                        ovf_q       <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= StAccept;
                    end
                end

                StAccept: begin
                    if (cmd_fire) begin
                        if (enc_legal) begin
                            wdata_q     <= enc_word;
                            last_q      <= bus.cmd_last;
                            cmd_ready_q <= 1'b0;
                            we_q        <= 1'b1;
                            state_q     <= StWrite;
                        end else begin
                            // Illegal command is dropped but may still end the program.
                            err_q <= 1'b1;
                            if (bus.cmd_last) begin
                                cmd_ready_q <= 1'b0;
                                done_q      <= 1'b1;
                                state_q     <= StDone;
                            end
                        end
                    end
                end

                StWrite: begin
                    if (bus.imem_ready) begin
                        count_q <= count_q + CountOne;
                        we_q    <= 1'b0;
                        if (last_q) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else if (addr_q == LastAddr) begin
                            // Memory is full and the program has not ended.
                            ovf_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            addr_q      <= addr_q + AddrOne;
                            cmd_ready_q <= 1'b1;
                            state_q     <= StAccept;
                        end
                    end
                end

                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    cmd_ready_q <= 1'b0;
                    we_q        <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_op         = err_q;
    assign overflow       = ovf_q;
    assign word_count     = count_q;

endmodule

// File: tb/tb_imem_program_encoder.sv
// Bench for imem_program_encoder: directed scenarios plus randomized program
// loads checked against a list-based model of the loader.
module tb_imem_program_encoder;

    localparam int unsigned ADDR_W     = 2;
    localparam int unsigned START_ADDR = 0;
    localparam int unsigned DEPTH      = 1 << ADDR_W;

    typedef struct packed {
        logic [2:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
        logic        last;
    } cmd_t;

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic            start = 1'b0;
    logic            busy;
    logic            done;
    logic            err_op;
    logic            overflow;
    logic [ADDR_W:0] word_count;

    imem_program_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    imem_program_encoder #(
        .ADDR_W    (ADDR_W),
        .START_ADDR(START_ADDR)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err_op    (err_op),
        .overflow  (overflow),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    cmd_t              cmds[$];
    logic [ADDR_W-1:0] log_addr[$];
    logic [31:0]       log_data[$];
    int                consumed;
    int                we_cycles;

    int unsigned       exp_addr[$];
    logic [31:0]       exp_data[$];
    logic              exp_err;
    logic              exp_ovf;
    int                exp_consumed;

    // Reference encoding built from the instruction-format table.
    function automatic logic [31:0] ref_word(input cmd_t c);
        int unsigned opc[6] = '{0, 35, 43, 4, 8, 2};
        logic [31:0] w;
        if (c.op == 3'd0)
            w = (32'(c.rs) << 21) | (32'(c.rt) << 16) | (32'(c.rd) << 11) | 32'(c.funct);
        else if (c.op == 3'd5)
            w = (opc[5] << 26) | 32'(c.target);
        else
            w = (opc[c.op] << 26) | (32'(c.rs) << 21) | (32'(c.rt) << 16) | 32'(c.imm);
        return w;
    endfunction

    // Walk the program list as the loader should and record the expected writes.
    task automatic model_load();
        int unsigned a = START_ADDR;
        exp_addr.delete();
        exp_data.delete();
        exp_err      = 1'b0;
        exp_ovf      = 1'b0;
        exp_consumed = 0;
        foreach (cmds[i]) begin
            exp_consumed = i + 1;
            if (cmds[i].op > 3'd5) begin
                exp_err = 1'b1;
                if (cmds[i].last) break;
                continue;
            end
            exp_addr.push_back(a);
            exp_data.push_back(ref_word(cmds[i]));
            if (cmds[i].last) break;
            if (a == DEPTH - 1) begin
                exp_ovf = 1'b1;
                break;
            end
            a++;
        end
    endtask

    function automatic cmd_t mk(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [5:0] funct,
                                input logic [15:0] imm, input logic [25:0] target,
                                input logic last);
        cmd_t c;
        c = '{op, rs, rt, rd, funct, imm, target, last};
        return c;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.op     = 3'($urandom_range(0, 7));
        c.rs     = 5'($urandom);
        c.rt     = 5'($urandom);
        c.rd     = 5'($urandom);
        c.funct  = 6'($urandom);
        c.imm    = 16'($urandom);
        c.target = 26'($urandom);
        c.last   = 1'b0;
        return c;
    endfunction

    task automatic drive_cmd(input logic valid, input cmd_t c);
        bus.cmd_valid  = valid;
        bus.cmd_op     = c.op;
        bus.cmd_rs     = c.rs;
        bus.cmd_rt     = c.rt;
        bus.cmd_rd     = c.rd;
        bus.cmd_funct  = c.funct;
        bus.cmd_imm    = c.imm;
        bus.cmd_target = c.target;
        bus.cmd_last   = c.last;
    endtask

    // Run one program load. mode 0: always ready; 1: random gaps; 2: memory stalls 3 cycles.
    // Inputs change and outputs are sampled on the falling edge.
    task automatic run_load(input int mode);
        int   stall = 0;
        logic prev_legal_hs = 1'b0;
        logic prev_hold = 1'b0;
        logic got_done = 1'b0;
        logic valid;
        logic [ADDR_W-1:0] pa = '0;
        logic [31:0] pd = '0;
        log_addr.delete();
        log_data.delete();
        consumed  = 0;
        we_cycles = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (prev_legal_hs) begin
                total++;
                if (bus.imem_we !== 1'b1) begin
                    bad++;
                    $display("FAIL latency: imem_we=%b required 1 after handshake", bus.imem_we);
                end
            end
            if (prev_hold) begin
                total++;
                if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, pa, pd}) begin
                    bad++;
                    $display("FAIL hold: we=%b addr=%0d data=%h required 1 %0d %h",
                             bus.imem_we, bus.imem_addr, bus.imem_wdata, pa, pd);
                end
            end
            total++;
            if ((bus.imem_we & bus.cmd_ready) !== 1'b0) begin
                bad++;
                $display("FAIL overlap: imem_we=%b cmd_ready=%b required not both",
                         bus.imem_we, bus.cmd_ready);
            end
            if (done === 1'b1) begin
                got_done = 1'b1;
                start = 1'b0;
                bus.cmd_valid = 1'b0;
                break;
            end
            // start while busy must be ignored
            start = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            valid = (consumed < cmds.size()) && (mode != 1 || $urandom_range(0, 3) != 0);
            drive_cmd(valid, valid ? cmds[consumed] : rand_cmd());
            if (mode == 0)      bus.imem_ready = 1'b1;
            else if (mode == 1) bus.imem_ready = ($urandom_range(0, 2) != 0);
            else                bus.imem_ready = (stall >= 3);
            if (bus.imem_we) begin
                we_cycles++;
                if (bus.imem_ready) begin
                    log_addr.push_back(bus.imem_addr);
                    log_data.push_back(bus.imem_wdata);
                end else begin
                    stall++;
                end
            end
            prev_hold     = bus.imem_we && !bus.imem_ready;
            pa            = bus.imem_addr;
            pd            = bus.imem_wdata;
            prev_legal_hs = valid && bus.cmd_ready && (bus.cmd_op <= 3'd5);
            if (valid && bus.cmd_ready) consumed++;
            @(negedge clk);
        end
        total++;
        if (!got_done) begin
            bad++;
            $display("FAIL timeout: done=%b required 1 within 400 cycles", done);
        end
        bus.imem_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({done, busy} !== 2'b00) begin
            bad++;
            $display("FAIL done_pulse: done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_reset();
        bus.cmd_valid  = 1'b0;
        bus.imem_ready = 1'b0;
        drive_cmd(1'b0, rand_cmd());
        #1 reset_n = 1'b0;
        #1;
        total++;
        if ({busy, done, err_op, overflow, bus.cmd_ready, bus.imem_we} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: busy=%b done=%b err=%b ovf=%b rdy=%b we=%b required 0",
                     busy, done, err_op, overflow, bus.cmd_ready, bus.imem_we);
        end
        total++;
        if ({word_count, bus.imem_addr, bus.imem_wdata} !== {(ADDR_W + 1)'(0),
                                                               ADDR_W'(START_ADDR), 32'h0}) begin
            bad++;
            $display("FAIL reset_values: count=%0d addr=%0d data=%h required 0 %0d 0",
                     word_count, bus.imem_addr, bus.imem_wdata, START_ADDR);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_r_type();
        cmds = '{mk(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1'b1)};
        run_load(0);
        total++;
        if (log_data.size() != 1 || log_addr[0] !== 2'd0 || log_data[0] !== 32'h00221820) begin
            bad++;
            $display("FAIL r_type: writes=%0d addr=%0d data=%h required 1 0 00221820",
                     log_data.size(), log_addr[0], log_data[0]);
        end
        total++;
        if (word_count !== 3'd1) begin
            bad++;
            $display("FAIL r_count: word_count=%0d required 1", word_count);
        end
    endtask

    task automatic test_lw_beq();
        cmds = '{mk(3'd1, 5'd0, 5'd8, 5'd0, 6'h0, 16'h0004, 26'h0, 1'b0),
                 mk(3'd3, 5'd8, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0, 1'b1)};
        run_load(0);
        total++;
        if (log_data.size() != 2 || log_addr[0] !== 2'd0 || log_data[0] !== 32'h8C080004 ||
            log_addr[1] !== 2'd1 || log_data[1] !== 32'h1100FFFF) begin
            bad++;
            $display("FAIL lw_beq: writes=%0d %0d:%h %0d:%h required 2 0:8c080004 1:1100ffff",
                     log_data.size(), log_addr[0], log_data[0], log_addr[1], log_data[1]);
        end
    endtask

    task automatic test_stall_j();
        cmds = '{mk(3'd5, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000010, 1'b1)};
        run_load(2);
        total++;
        if (we_cycles != 4) begin
            bad++;
            $display("FAIL stall_we: imem_we cycles=%0d required 4", we_cycles);
        end
        total++;
        if (log_data.size() != 1 || log_data[0] !== 32'h08000010) begin
            bad++;
            $display("FAIL stall_data: writes=%0d data=%h required 1 08000010",
                     log_data.size(), log_data[0]);
        end
    endtask

    task automatic test_illegal();
        cmds = '{mk(3'd6, 5'd3, 5'd4, 5'd5, 6'h1, 16'h1234, 26'h0, 1'b0),
                 mk(3'd4, 5'd0, 5'd9, 5'd0, 6'h0, 16'h0005, 26'h0, 1'b1)};
        run_load(0);
        total++;
        if (err_op !== 1'b1 || word_count !== 3'd1) begin
            bad++;
            $display("FAIL illegal_flags: err_op=%b word_count=%0d required 1 1",
                     err_op, word_count);
        end
        total++;
        if (log_data.size() != 1 || log_addr[0] !== 2'd0 || log_data[0] !== 32'h20090005) begin
            bad++;
            $display("FAIL illegal_write: writes=%0d addr=%0d data=%h required 1 0 20090005",
                     log_data.size(), log_addr[0], log_data[0]);
        end
    endtask

    task automatic test_overflow();
        cmds.delete();
        for (int i = 0; i < 5; i++)
            cmds.push_back(mk(3'd2, 5'd1, 5'd2, 5'd0, 6'h0, 16'(i), 26'h0, 1'b0));
        run_load(0);
        total++;
        if (overflow !== 1'b1 || consumed != 4 || word_count !== 3'd4) begin
            bad++;
            $display("FAIL overflow: overflow=%b accepted=%0d word_count=%0d required 1 4 4",
                     overflow, consumed, word_count);
        end
        total++;
        if (log_data.size() != 4) begin
            bad++;
            $display("FAIL overflow_writes: writes=%0d required 4", log_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (log_addr[i] !== ADDR_W'(i) || log_data[i] !== (32'hAC220000 + 32'(i))) begin
                    bad++;
                    $display("FAIL overflow_word%0d: addr=%0d data=%h required %0d %h", i,
                             log_addr[i], log_data[i], i, 32'hAC220000 + 32'(i));
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        bus.imem_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drive_cmd(1'b1, mk(3'd7, 5'd1, 5'd1, 5'd1, 6'h1, 16'h1, 26'h1, 1'b0));
        @(negedge clk);
        drive_cmd(1'b1, mk(3'd2, 5'd1, 5'd2, 5'd0, 6'h0, 16'h7, 26'h0, 1'b0));
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        total++;
        if ({bus.imem_we, err_op, busy} !== 3'b111) begin
            bad++;
            $display("FAIL pre_abort: we=%b err=%b busy=%b required 1 1 1",
                     bus.imem_we, err_op, busy);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({bus.imem_we, busy, err_op, overflow, bus.cmd_ready, word_count} !== 8'b0 ||
            bus.imem_addr !== ADDR_W'(START_ADDR)) begin
            bad++;
            $display("FAIL abort: we=%b busy=%b err=%b ovf=%b rdy=%b cnt=%0d addr=%0d required 0",
                     bus.imem_we, busy, err_op, overflow, bus.cmd_ready, word_count,
                     bus.imem_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        cmds = '{mk(3'd5, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h3ABCDEF, 1'b1)};
        run_load(0);
        total++;
        if (log_data.size() != 1 || log_addr[0] !== ADDR_W'(START_ADDR) ||
            log_data[0] !== 32'h0BABCDEF) begin
            bad++;
            $display("FAIL resume: writes=%0d addr=%0d data=%h required 1 %0d 0babcdef",
                     log_data.size(), log_addr[0], log_data[0], START_ADDR);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            int n = $urandom_range(1, 7);
            cmds.delete();
            for (int i = 0; i < n; i++) cmds.push_back(rand_cmd());
            cmds[n-1].last = 1'b1;
            if ($urandom_range(0, 3) == 0) cmds[$urandom_range(0, n - 1)].last = 1'b1;
            model_load();
            run_load(1);
            total++;
            if (consumed != exp_consumed || log_data.size() != exp_data.size()) begin
                bad++;
                $display("FAIL rand%0d_shape: accepted=%0d writes=%0d required %0d %0d", t,
                         consumed, log_data.size(), exp_consumed, exp_data.size());
            end else begin
                foreach (exp_data[i]) begin
                    total++;
                    if (log_addr[i] !== ADDR_W'(exp_addr[i]) || log_data[i] !== exp_data[i]) begin
                        bad++;
                        $display("FAIL rand%0d_word%0d: addr=%0d data=%h required %0d %h", t, i,
                                 log_addr[i], log_data[i], exp_addr[i], exp_data[i]);
                    end
                end
            end
            total++;
            if ({err_op, overflow, word_count} !== {exp_err, exp_ovf,
                                                     (ADDR_W + 1)'(exp_data.size())}) begin
                bad++;
                $display("FAIL rand%0d_flags: err=%b ovf=%b cnt=%0d required %b %b %0d", t,
                         err_op, overflow, word_count, exp_err, exp_ovf, exp_data.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_lw_beq();
        test_stall_j();
        test_illegal();
        test_overflow();
        test_reset_mid_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
